// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with start/busy/done handshake.
// Multiplies WIDTH-bit operands into a 2*WIDTH-bit product. The product is
// unsigned, or two's complement when signed_mode is set.
// The latency is a fixed WIDTH+2 clock edges, whatever the operand values.
// The unit works on magnitudes and applies the sign in a final cycle.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  // The counter must hold values from WIDTH-1 down to 0.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t                state;
  logic [2*WIDTH:0]      acc;      // upper WIDTH+1 bits: partial sum; lower WIDTH: multiplier
  logic [WIDTH-1:0]      mcand;    // latched multiplicand magnitude
  logic [CW-1:0]         count;    // iterations remaining, minus one
  logic                  neg;      // the result must be negated in SIGN

  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic [WIDTH:0]        acc_sum;
  logic [2*WIDTH:0]      acc_step;
  logic [2*WIDTH-1:0]    mag;

  // Take the operand magnitudes at acceptance.
  // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add step.
  // Add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    acc_sum  = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
    acc_step = {1'b0, acc_sum, acc[WIDTH-1:1]};
    mag      = acc[2*WIDTH-1:0];
  end

  // Control FSM and datapath registers.
  // Reset abandons any operation in flight, and no done pulse follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      count <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            acc   <= {{(WIDTH+1){1'b0}}, b_mag};
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            count <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count - CW'(1);
          if (count == '0) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          z     <= neg ? (~mag + (2*WIDTH)'(1)) : mag;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier with WIDTH=4.
// The driver queues the expected product and the cycle in which done should appear.
// The monitor checks each done pulse against the head of that queue.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] z;

  typedef struct {
    logic [2*W-1:0] z;
    int             cyc;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic done_prev = 1'b0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .z           (z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: on every done pulse, pop the head of the queue and check the product and its timing.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      done_prev <= 1'b0;
    end else begin
      if (done && done_prev) begin
        n_vec++; n_bad++;
        $display("FAIL done_width: done high two cycles in a row at cycle %0d", cycle_cnt);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_done: done with no pending op at cycle %0d, z=%h", cycle_cnt, z);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if (z !== e.z) begin
            n_bad++;
            $display("FAIL product: a=%h b=%h sm=%0b z=%h expected %h", e.a, e.b, e.sm, z, e.z);
          end else begin
            $display("op a=%h b=%h sm=%0b z=%h ok", e.a, e.b, e.sm, z);
          end
          n_vec++;
          if (cycle_cnt != e.cyc) begin
            n_bad++;
            $display("FAIL latency: a=%h b=%h done at cycle %0d expected %0d", e.a, e.b, cycle_cnt, e.cyc);
          end
        end
      end
      done_prev <= done;
    end
  end

  // Wait until the DUT is idle, then issue one op and queue its expected result.
  // Afterwards the operands are scrambled to show that later input changes are ignored.
  // With hold set, start stays high so that the next op goes back to back.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tsm, input logic [2*W-1:0] texp, input logic hold);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, guard);
      return;
    end
    a = ta; b = tb_v; signed_mode = tsm; start = 1'b1;
    e.z = texp; e.cyc = cycle_cnt + W + 2; e.a = ta; e.b = tb_v; e.sm = tsm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = ~ta; b = ~tb_v; signed_mode = ~tsm;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] z;
  } vec_t;

  vec_t vecs[15] = '{
    '{4'hF, 4'hF, 1'b0, 8'hE1},  // 15*15 = 225
    '{4'h8, 4'h8, 1'b1, 8'h40},  // -8*-8 = 64
    '{4'hD, 4'h5, 1'b1, 8'hF1},  // -3*5 = -15
    '{4'h7, 4'hF, 1'b1, 8'hF9},  // 7*-1 = -7
    '{4'h7, 4'hF, 1'b0, 8'h69},  // 7*15 = 105
    '{4'h0, 4'hF, 1'b0, 8'h00},
    '{4'hF, 4'h0, 1'b1, 8'h00},
    '{4'h8, 4'h7, 1'b1, 8'hC8},  // -8*7 = -56
    '{4'hF, 4'hF, 1'b1, 8'h01},  // -1*-1 = 1
    '{4'h8, 4'hF, 1'b1, 8'h08},  // -8*-1 = 8
    '{4'h7, 4'h7, 1'b1, 8'h31},  // 49
    '{4'h8, 4'h1, 1'b0, 8'h08},
    '{4'hC, 4'hB, 1'b0, 8'h84},  // 12*11 = 132
    '{4'hC, 4'hB, 1'b1, 8'h14},  // -4*-5 = 20
    '{4'h1, 4'h8, 1'b1, 8'hF8}   // 1*-8 = -8
  };

  initial begin
    int guard;
    int sa;
    int sb_i;
    logic [W-1:0] va;
    logic [W-1:0] vb;

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (z !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: z=%h busy=%b done=%b expected 00/0/0", z, busy, done);
    end
    reset = 1'b0;

    // Busy profile for one op: high for W+1 samples, then low while done is high.
    run_op(4'hF, 4'hF, 1'b0, 8'hE1, 1'b0);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_profile: step %0d busy=%b done=%b expected 1/0", k, busy, done);
      end
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_cycle: busy=%b done=%b expected 0/1", busy, done);
    end

    // Directed vectors. Each op issues as soon as the previous one's done appears.
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].z, 1'b0);

    // Start held high: results come every W+2 cycles, and mid-op operand changes are ignored.
    run_op(4'h3, 4'h5, 1'b0, 8'h0F, 1'b1);
    run_op(4'hE, 4'h3, 1'b1, 8'hFA, 1'b1);   // -2*3 = -6
    run_op(4'h9, 4'h9, 1'b0, 8'h51, 1'b1);   // 81
    run_op(4'h9, 4'h9, 1'b1, 8'h31, 1'b0);   // -7*-7 = 49

    // An asynchronous reset in the middle of an op abandons it.
    run_op(4'hB, 4'hD, 1'b0, 8'h8F, 1'b0);   // 11*13 = 143, never completes
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (z !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: z=%h busy=%b done=%b expected 00/0/0", z, busy, done);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    run_op(4'h6, 4'h5, 1'b1, 8'h1E, 1'b0);   // 30

    // Full sweep of every W=4 operand pair in both modes, checked against plain integer products.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ism = 0; ism < 2; ism++) begin
          va = 4'(ia);
          vb = 4'(ib);
          sa   = (ism == 1 && va[W-1]) ? ia - 16 : ia;
          sb_i = (ism == 1 && vb[W-1]) ? ib - 16 : ib;
          run_op(va, vb, 1'(ism), 8'(sa * sb_i), 1'b0);
        end
      end
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
